ma_stage: RTL and testbench
===========================

Name: ma_stage

Overview:
- Memory-access pipeline stage of the 5-stage CPU. Sits between the EX stage and the WB stage.
- Accepts the EX payload and waits for the data-SRAM read response on loads.
- Performs byte/halfword extraction and extension, then produces the 70-bit bus that the WB stage consumes.
- Also drives a forwarding bus for ID-stage hazard bypass.

Parameters:
- none (bus widths fixed by pipeline bus format)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_validout  in  1  EX holds a valid instruction for MA
- wb_allowin  in  1  WB can accept data this cycle
- ma_allowin  out  1  MA can accept from EX this cycle
- ma_validout  out  1  MA presents a valid, completed instruction to WB
- ex_to_ma_bus  in  74  {ld_op[73:71], res_from_mem[70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}
- data_sram_rdata  in  32  load read data, valid when data_sram_data_ok=1
- data_sram_data_ok  in  1  single-cycle response strobe for the outstanding load
- ma_to_wb_bus  out  70  {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}
- ma_fwd_bus  out  38  {fwd_we[37], dest[36:32], final_result[31:0]}; fwd_we = valid & gr_we & readygo

Behaviour:
- Registers:
  - valid; bus_r[73:0]; got_data; rdata_buf[31:0].
  - All cleared to 0 on rst.
- Reset output values:
  - ma_validout=0, ma_allowin=1.
  - ma_to_wb_bus=0, ma_fwd_bus=0 (fwd_we=0).
- Load response and readygo:
  - readygo = ~res_from_mem | got_data | data_sram_data_ok.
  - Non-load: readygo=1, so latency is 1 cycle in MA.
  - Load: MA holds until data_ok arrives. data_ok may come in the first cycle valid=1 (zero stall) or any later cycle.
- Handshake:
  - ma_allowin = ~valid | (readygo & wb_allowin).
  - ma_validout = valid & readygo.
  - valid <= ex_validout when ma_allowin.
  - bus_r <= ex_to_ma_bus when ex_validout & ma_allowin.
- Response buffering FSM (per instruction), states EMPTY / WAIT / HELD:
  - EMPTY (valid=0) -> WAIT on accept of a load; -> EMPTY on accept of a non-load (got_data stays 0).
  - WAIT: data_ok & ~wb_allowin -> HELD (rdata_buf<=rdata, got_data<=1). data_ok & wb_allowin -> instruction leaves, buffer not written.
  - HELD: on leave (wb_allowin), got_data<=0.
  - got_data is cleared whenever a new instruction is accepted, taking priority over a same-cycle set.
- Load data source: rdata = got_data ? rdata_buf : data_sram_rdata.
- Load data extraction (a = alu_result[1:0]):
  - ld_op=000 LW: rdata.
  - 001 LB: sign-extended byte a.
  - 010 LBU: zero-extended byte a.
  - 011 LH: sign-extended half selected by a[1]; a[0] ignored.
  - 100 LHU: zero-extended half selected by a[1]; a[0] ignored.
  - 101-111: treated as LW.
- final_result = res_from_mem ? extracted : alu_result.
- ma_to_wb_bus carries raw gr_we; WB gates it with its own valid.
- Boundaries:
  - data_ok while valid=0, or for a non-load, or in HELD: ignored, no state change.
  - Back-to-back loads: the new load enters WAIT in the same edge the old one leaves. A data_ok in that cycle belongs to the old load only.
  - rst during WAIT or HELD: instruction dropped, got_data=0. A late data_ok after reset is ignored because valid=0.
  - wb_allowin=0 with valid non-load: hold, ma_allowin=0, outputs stable.

Optional Feature:
- Macro MA_STALL_CNT_EN.
- When defined:
  - Adds output ma_stall_cnt (32 bits).
  - Increments each cycle valid & res_from_mem & ~readygo; saturates at 0xFFFFFFFF.
  - Cleared by rst only.
- When undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles, ex_validout=1.
  - Response: ma_validout=0, ma_allowin=1, ma_fwd_bus=0.
  - Then: first instruction accepted 1 cycle after rst falls.
- ALU op:
  - Stimulus: res_from_mem=0, gr_we=1, dest=5, alu_result=0x1234, pc=0xBFC00000, wb_allowin=1.
  - Response: next cycle ma_validout=1, ma_to_wb_bus={1,5,0x1234,0xBFC00000}.
- LB with 2-cycle stall:
  - Stimulus: ld_op=001, addr=0x...2; data_ok arrives in the 3rd valid cycle with rdata=0x0080FF00.
  - Response: ma_validout=0 for 2 cycles, then final_result=0xFFFFFF80.
  - Counter (MA_STALL_CNT_EN) = 2.
- Held data:
  - Stimulus: LHU addr=0x...2; data_ok with rdata=0xBEEF0001 while wb_allowin=0; wb_allowin rises 3 cycles later.
  - Response: final_result=0x0000BEEF, stable throughout; data_ok toggled again while HELD has no effect.
- Back-to-back:
  - Stimulus: LW then LBU addr=3, each data_ok arriving on its first cycle (rdata=0x11223344 then 0xAB000000).
  - Response: consecutive ma_validout cycles with final_result 0x11223344 then 0x000000AB.
- Reset mid-WAIT:
  - Stimulus: assert rst during a load's WAIT, then pulse data_ok after rst falls.
  - Response: ma_validout stays 0 and no WB transfer occurs.

Source files
------------

// File: rtl/ma_stage.sv
// ma_stage: memory-access pipeline stage; waits for the load response, extracts/extends load data, drives WB and forwarding buses.
// Optional stall counter output ma_stall_cnt is enabled by defining MA_STALL_CNT_EN.
module ma_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_validout,
  input  logic        wb_allowin,
  output logic        ma_allowin,
  output logic        ma_validout,
  input  logic [73:0] ex_to_ma_bus,
  input  logic [31:0] data_sram_rdata,
  input  logic        data_sram_data_ok,
`ifdef MA_STALL_CNT_EN
  output logic [31:0] ma_stall_cnt,
`endif
  output logic [69:0] ma_to_wb_bus,
  output logic [37:0] ma_fwd_bus
);
  typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_HELD} state_t;
  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic [73:0] bus_q, bus_d;
  logic [31:0] rdata_buf_q, rdata_buf_d;
  logic [2:0]  ld_op;
  logic        res_from_mem, gr_we, got_data, readygo, fwd_we;
  logic [4:0]  dest;
  logic [31:0] alu_result, pc, rdata, extracted, final_result;
  logic [1:0]  a;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  assign {ld_op, res_from_mem, gr_we, dest, alu_result, pc} = bus_q;
  assign a            = alu_result[1:0];
  assign got_data     = state_q == S_HELD;
  assign readygo      = ~res_from_mem | got_data | data_sram_data_ok;
  assign ma_allowin   = ~valid_q | (readygo & wb_allowin);
  assign ma_validout  = valid_q & readygo;
  assign rdata        = got_data ? rdata_buf_q : data_sram_rdata;
  assign bsel         = 8'(rdata >> {a, 3'b000});
  assign hsel         = a[1] ? rdata[31:16] : rdata[15:0];
  assign extracted    = ld_op == 3'd1 ? {{24{bsel[7]}}, bsel} :
                        ld_op == 3'd2 ? {24'd0, bsel} :
                        ld_op == 3'd3 ? {{16{hsel[15]}}, hsel} :
                        ld_op == 3'd4 ? {16'd0, hsel} : rdata;
  assign final_result = res_from_mem ? extracted : alu_result;
  assign fwd_we       = valid_q & gr_we & readygo;
  assign ma_to_wb_bus = {gr_we, dest, final_result, pc};
  assign ma_fwd_bus   = {fwd_we, dest, final_result};
  // A new accept always restarts the per-instruction state, overriding any same-cycle capture.
  always_comb begin
    valid_d     = ma_allowin ? ex_validout : valid_q;
    bus_d       = (ex_validout & ma_allowin) ? ex_to_ma_bus : bus_q;
    state_d     = ma_allowin ? ((ex_validout & ex_to_ma_bus[70]) ? S_WAIT : S_EMPTY) :
                  (state_q == S_WAIT && data_sram_data_ok) ? S_HELD : state_q;
    rdata_buf_d = (state_q == S_WAIT && data_sram_data_ok && !ma_allowin) ? data_sram_rdata : rdata_buf_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      bus_q       <= '0;
      state_q     <= S_EMPTY;
      rdata_buf_q <= '0;
    end else begin
      valid_q     <= valid_d;
      bus_q       <= bus_d;
      state_q     <= state_d;
      rdata_buf_q <= rdata_buf_d;
    end
  end
`ifdef MA_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  assign ma_stall_cnt = stall_cnt_q;
  always_comb stall_cnt_d = (valid_q & res_from_mem & ~readygo & ~&stall_cnt_q) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else stall_cnt_q <= stall_cnt_d;
  end
`endif
endmodule

// File: tb/tb_ma_stage.sv
// tb_ma_stage: table-driven load-extraction vectors plus directed handshake sequences for ma_stage.
module tb_ma_stage;
  logic        clk = 0, rst, ex_validout, wb_allowin, ma_allowin, ma_validout, data_sram_data_ok;
  logic [73:0] ex_to_ma_bus;
  logic [31:0] data_sram_rdata;
  logic [69:0] ma_to_wb_bus;
  logic [37:0] ma_fwd_bus;
`ifdef MA_STALL_CNT_EN
  logic [31:0] ma_stall_cnt;
`endif
  int checks = 0, failures = 0;

  ma_stage dut (
    .clk(clk), .rst(rst), .ex_validout(ex_validout), .wb_allowin(wb_allowin),
    .ma_allowin(ma_allowin), .ma_validout(ma_validout), .ex_to_ma_bus(ex_to_ma_bus),
    .data_sram_rdata(data_sram_rdata), .data_sram_data_ok(data_sram_data_ok),
`ifdef MA_STALL_CNT_EN
    .ma_stall_cnt(ma_stall_cnt),
`endif
    .ma_to_wb_bus(ma_to_wb_bus), .ma_fwd_bus(ma_fwd_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rfm;
    logic [2:0] ld_op;
    logic [1:0] a;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [11];

  function automatic logic [73:0] mk(input logic [2:0] ld_op, input logic rfm, input logic we,
                                     input logic [4:0] dest, input logic [31:0] alu, input logic [31:0] pc);
    return {ld_op, rfm, we, dest, alu, pc};
  endfunction

  task automatic chk(input string name, input logic [69:0] got, input logic [69:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  initial begin
    vecs[0]  = '{1, 3'b000, 2'd0, 32'h11223344, 32'h11223344};
    vecs[1]  = '{1, 3'b001, 2'd0, 32'h000000F0, 32'hFFFFFFF0};
    vecs[2]  = '{1, 3'b001, 2'd3, 32'h7F000000, 32'h0000007F};
    vecs[3]  = '{1, 3'b010, 2'd1, 32'h0000C300, 32'h000000C3};
    vecs[4]  = '{1, 3'b011, 2'd0, 32'h00008001, 32'hFFFF8001};
    vecs[5]  = '{1, 3'b011, 2'd1, 32'h80017FFF, 32'h00007FFF};
    vecs[6]  = '{1, 3'b100, 2'd3, 32'hF00D1234, 32'h0000F00D};
    vecs[7]  = '{1, 3'b011, 2'd2, 32'h9ABC0000, 32'hFFFF9ABC};
    vecs[8]  = '{1, 3'b101, 2'd2, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[9]  = '{1, 3'b111, 2'd1, 32'h01020304, 32'h01020304};
    vecs[10] = '{0, 3'b001, 2'd1, 32'hFFFFFFFF, 32'hABC00001};

    // reset with EX already presenting an instruction
    rst = 1; ex_validout = 1; wb_allowin = 1; data_sram_data_ok = 0; data_sram_rdata = 0;
    ex_to_ma_bus = mk(3'b000, 0, 1, 5'd5, 32'h00001234, 32'hBFC00000);
    tick; tick; settle;
    chk("rst_validout", 70'(ma_validout), 70'(0));
    chk("rst_allowin", 70'(ma_allowin), 70'(1));
    chk("rst_fwd", 70'(ma_fwd_bus), 70'(0));
    chk("rst_wb_bus", ma_to_wb_bus, 70'(0));
`ifdef MA_STALL_CNT_EN
    chk("rst_cnt", 70'(ma_stall_cnt), 70'(0));
`endif
    rst = 0;
    tick; settle;
    chk("alu_validout", 70'(ma_validout), 70'(1));
    chk("alu_wb_bus", ma_to_wb_bus, {1'b1, 5'd5, 32'h00001234, 32'hBFC00000});
    chk("alu_fwd", 70'(ma_fwd_bus), 70'({1'b1, 5'd5, 32'h00001234}));
    ex_validout = 0;
    tick; settle;
    chk("alu_leave", 70'(ma_validout), 70'(0));

    // WB stall on a non-load: hold, outputs stable, EX blocked
    ex_validout = 1; wb_allowin = 0;
    ex_to_ma_bus = mk(3'b000, 0, 1, 5'd7, 32'h0000CAFE, 32'h00000100);
    tick;
    ex_to_ma_bus = mk(3'b000, 0, 1, 5'd8, 32'h00000BAD, 32'h00000200);
    settle;
    chk("hold_allowin", 70'(ma_allowin), 70'(0));
    tick; settle;
    chk("hold_validout", 70'(ma_validout), 70'(1));
    chk("hold_bus", ma_to_wb_bus, {1'b1, 5'd7, 32'h0000CAFE, 32'h00000100});
    ex_validout = 0; wb_allowin = 1;
    tick; settle;
    chk("hold_leave", 70'(ma_validout), 70'(0));

    // table: loads with data_ok already high at accept (ignored while valid=0) and in first valid cycle
    for (int i = 0; i < 11; i++) begin
      ex_validout = 1; wb_allowin = 1; data_sram_data_ok = 1; data_sram_rdata = vecs[i].rdata;
      ex_to_ma_bus = mk(vecs[i].ld_op, vecs[i].rfm, 1, 5'd4, 32'hABC00000 | 32'(vecs[i].a), 32'h00400000);
      tick;
      ex_validout = 0;
      settle;
      chk($sformatf("vec%0d_valid", i), 70'(ma_validout), 70'(1));
      chk($sformatf("vec%0d_result", i), 70'(ma_to_wb_bus[63:32]), 70'(vecs[i].exp));
      tick;
      data_sram_data_ok = 0;
      settle;
      chk($sformatf("vec%0d_leave", i), 70'(ma_validout), 70'(0));
    end

    // LB with two stall cycles
    ex_validout = 1; wb_allowin = 1;
    ex_to_ma_bus = mk(3'b001, 1, 1, 5'd3, 32'h00001002, 32'h00000300);
    tick;
    ex_validout = 0; settle;
    chk("lb_stall1", 70'(ma_validout), 70'(0));
    chk("lb_stall1_allowin", 70'(ma_allowin), 70'(0));
    chk("lb_stall1_fwd_we", 70'(ma_fwd_bus[37]), 70'(0));
    tick; settle;
    chk("lb_stall2", 70'(ma_validout), 70'(0));
    tick;
    data_sram_data_ok = 1; data_sram_rdata = 32'h0080FF00; settle;
    chk("lb_valid", 70'(ma_validout), 70'(1));
    chk("lb_result", 70'(ma_to_wb_bus[63:32]), 70'(32'hFFFFFF80));
`ifdef MA_STALL_CNT_EN
    chk("lb_cnt", 70'(ma_stall_cnt), 70'(2));
`endif
    tick;
    data_sram_data_ok = 0; settle;
    chk("lb_leave", 70'(ma_validout), 70'(0));

    // LHU response captured while WB is stalled, then replayed from the buffer
    ex_validout = 1; wb_allowin = 0;
    ex_to_ma_bus = mk(3'b100, 1, 1, 5'd9, 32'h00002002, 32'h00000400);
    tick;
    ex_validout = 0; data_sram_data_ok = 1; data_sram_rdata = 32'hBEEF0001; settle;
    chk("held_c0", {6'd0, ma_validout, ma_to_wb_bus[63:32]}, {6'd0, 1'b1, 32'h0000BEEF});
    tick;
    data_sram_data_ok = 0; data_sram_rdata = 32'h12345678; settle;
    chk("held_c1", {6'd0, ma_validout, ma_to_wb_bus[63:32]}, {6'd0, 1'b1, 32'h0000BEEF});
    tick;
    data_sram_data_ok = 1; data_sram_rdata = 32'hFFFFFFFF; settle;
    chk("held_c2", {6'd0, ma_validout, ma_to_wb_bus[63:32]}, {6'd0, 1'b1, 32'h0000BEEF});
    tick;
    data_sram_data_ok = 0; wb_allowin = 1; settle;
    chk("held_c3", {6'd0, ma_validout, ma_to_wb_bus[63:32]}, {6'd0, 1'b1, 32'h0000BEEF});
    chk("held_allowin", 70'(ma_allowin), 70'(1));
    tick; settle;
    chk("held_leave", 70'(ma_validout), 70'(0));

    // back-to-back loads, each answered on its first cycle
    ex_validout = 1; wb_allowin = 1;
    ex_to_ma_bus = mk(3'b000, 1, 1, 5'd1, 32'h00000100, 32'h00000500);
    tick;
    ex_to_ma_bus = mk(3'b010, 1, 1, 5'd2, 32'h00000203, 32'h00000504);
    data_sram_data_ok = 1; data_sram_rdata = 32'h11223344; settle;
    chk("b2b_first", {5'd0, ma_validout, ma_to_wb_bus[68:32]}, {5'd0, 1'b1, 5'd1, 32'h11223344});
    tick;
    ex_validout = 0; data_sram_rdata = 32'hAB000000; settle;
    chk("b2b_second", {5'd0, ma_validout, ma_to_wb_bus[68:32]}, {5'd0, 1'b1, 5'd2, 32'h000000AB});
    tick;
    data_sram_data_ok = 0; settle;
    chk("b2b_leave", 70'(ma_validout), 70'(0));

    // reset while a load waits, then a late response
    ex_validout = 1;
    ex_to_ma_bus = mk(3'b000, 1, 1, 5'd6, 32'h00000600, 32'h00000600);
    tick;
    ex_validout = 0; settle;
    chk("rwait_wait", 70'(ma_validout), 70'(0));
    rst = 1;
    tick;
    rst = 0; data_sram_data_ok = 1; data_sram_rdata = 32'h55555555; settle;
    chk("rwait_validout", 70'(ma_validout), 70'(0));
    chk("rwait_fwd", 70'(ma_fwd_bus), 70'(0));
    tick;
    data_sram_data_ok = 0; settle;
    chk("rwait_after", 70'(ma_validout), 70'(0));
    chk("rwait_allowin", 70'(ma_allowin), 70'(1));
`ifdef MA_STALL_CNT_EN
    chk("rwait_cnt", 70'(ma_stall_cnt), 70'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
